// File: rtl/mpu_pkg.sv
// Shared types and helpers for the matrix processing unit arithmetic ops.
package mpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_ACC  = 2'd2,
    ST_FIN  = 2'd3
  } det_state_e;

  // Bit offset of element (r,c) in a flat row-major matrix bus.
  function automatic int at(input int r, input int c, input int width, input int max_n);
    return width * (c + max_n * r);
  endfunction

  function automatic int fact(input int n);
    int f;
    f = 1;
    for (int i = 2; i <= n; i++) f = f * i;
    return f;
  endfunction

  // Accumulator width that holds any n!-term sum of WIDTH*MAX_N-bit products.
  function automatic int acc_width(input int width, input int max_n);
    return width * max_n + $clog2(fact(max_n)) + 1;
  endfunction

  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic fits(input logic signed [63:0] v, input int w);
    return (v <= sat_max(w)) && (v >= -sat_max(w) - 64'sd1);
  endfunction

  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
    if (v > sat_max(w)) return sat_max(w);
    if (v < -sat_max(w) - 64'sd1) return -sat_max(w) - 64'sd1;
    return v;
  endfunction

endpackage

// File: rtl/mpu_det_seq_if.sv
// Start/done job interface between the MPU controller and the determinant engine.
interface mpu_det_seq_if #(
  parameter int WIDTH     = 8,
  parameter int MAX_N     = 5,
  parameter int RES_WIDTH = 16
);
  localparam int SW = $clog2(MAX_N + 1);

  logic                         start;
  logic [SW-1:0]                size;
  logic [WIDTH*MAX_N*MAX_N-1:0] matrix;
  logic                         busy;
  logic                         done;
  logic signed [RES_WIDTH-1:0]  result;
  logic                         overflow;
  logic                         error;

  modport master (output start, size, matrix, input busy, done, result, overflow, error);
  modport slave  (input start, size, matrix, output busy, done, result, overflow, error);
endinterface

// File: rtl/mpu_perm_gen.sv
// Heap-order permutation generator: holds perm, the Heap counters and the parity.
// sign = 0 means an even permutation (+1), sign = 1 an odd one (-1).
module mpu_perm_gen #(
  parameter int MAX_N = 5,
  parameter int SW    = $clog2(MAX_N + 1),
  parameter int PW    = (MAX_N > 1) ? $clog2(MAX_N) : 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                init,
  input  logic                step,
  input  logic [SW-1:0]       n,
  output logic [MAX_N*PW-1:0] perm,
  output logic                sign,
  output logic                last
);

  logic [PW-1:0] p_q  [MAX_N];
  logic [PW-1:0] p_nx [MAX_N];
  logic [PW-1:0] c_q  [MAX_N];
  logic [PW-1:0] c_nx [MAX_N];
  logic [PW-1:0] sel;
  logic [PW-1:0] j;
  logic          sign_q;

  // Next permutation: lowest Heap counter below its index advances, lower ones clear.
  always_comb begin
    p_nx = p_q;
    c_nx = c_q;
    last = 1'b1;
    sel  = '0;
    j    = '0;
    for (int i = 1; i < MAX_N; i++) begin
      if (last && (i < int'(n)) && (int'(c_q[i]) < i)) begin
        last = 1'b0;
        sel  = PW'(i);
      end
    end
    if (!last) begin
      for (int i = 1; i < MAX_N; i++) begin
        if (i < int'(sel)) c_nx[i] = '0;
      end
      c_nx[sel] = c_q[sel] + PW'(1);
      // Odd index swaps with the slot named by its old counter, even index with slot 0.
      j         = sel[0] ? c_q[sel] : '0;
      p_nx[j]   = p_q[sel];
      p_nx[sel] = p_q[j];
    end
  end

  // Permutation state: identity on init, Heap step on request.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n || init) begin
      for (int i = 0; i < MAX_N; i++) begin
        p_q[i] <= PW'(i);
        c_q[i] <= '0;
      end
      sign_q <= 1'b0;
    end else if (step) begin
      p_q    <= p_nx;
      c_q    <= c_nx;
      sign_q <= ~sign_q;
    end
  end

  // Flatten the permutation for the top-level element select.
  always_comb begin
    perm = '0;
    for (int i = 0; i < MAX_N; i++) perm[i*PW +: PW] = p_q[i];
  end

  assign sign = sign_q;

endmodule

// File: rtl/mpu_det_seq.sv
// Sequential Leibniz determinant engine: one multiplier, one accumulator,
// permutations walked in Heap order by mpu_perm_gen.
module mpu_det_seq
  import mpu_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_N     = 5,
  parameter int RES_WIDTH = 16
) (
  input logic          clock,
  input logic          reset_n,
  mpu_det_seq_if.slave bus
);

  localparam int SW     = $clog2(MAX_N + 1);
  localparam int PW     = (MAX_N > 1) ? $clog2(MAX_N) : 1;
  localparam int PROD_W = WIDTH * MAX_N;
  localparam int ACC_W  = acc_width(WIDTH, MAX_N);
  localparam int MW     = WIDTH * MAX_N * MAX_N;
  localparam int MIW    = $clog2(MW);
  localparam int PIW    = (MAX_N * PW > 1) ? $clog2(MAX_N * PW) : 1;

  det_state_e                  state;
  logic [MW-1:0]               mat_q;
  logic [SW-1:0]               n_q;
  logic [SW-1:0]               k_q;
  logic signed [PROD_W-1:0]    prod_q;
  logic signed [PROD_W-1:0]    elem_x;
  logic signed [ACC_W-1:0]     acc_q;
  logic signed [ACC_W-1:0]     acc_nx;
  logic signed [WIDTH-1:0]     elem;
  logic [MAX_N*PW-1:0]         perm;
  logic [PW-1:0]               perm_k;
  logic [PIW-1:0]              pidx;
  logic [MIW-1:0]              eidx;
  logic                        sign;
  logic                        last;
  logic                        size_ok;
  logic                        pg_init;
  logic                        pg_step;
  logic signed [63:0]          acc_wide;
  logic signed [RES_WIDTH-1:0] acc_sat;
  logic                        busy_q;
  logic                        done_q;
  logic                        ovf_q;
  logic                        error_q;
  logic signed [RES_WIDTH-1:0] result_q;

  assign size_ok = (bus.size != '0) && (bus.size <= SW'(MAX_N));
  assign pg_init = (state == ST_IDLE) && bus.start && size_ok;
  assign pg_step = (state == ST_ACC) && !last;

  mpu_perm_gen #(.MAX_N(MAX_N), .SW(SW), .PW(PW)) u_perm (
    .clock   (clock),
    .reset_n (reset_n),
    .init    (pg_init),
    .step    (pg_step),
    .n       (n_q),
    .perm    (perm),
    .sign    (sign),
    .last    (last)
  );

  // Element m[k][perm[k]] for the current multiply step.
  assign pidx   = PIW'(int'(k_q) * PW);
  assign perm_k = perm[pidx +: PW];
  assign eidx   = MIW'(at(int'(k_q), int'(perm_k), WIDTH, MAX_N));
  assign elem   = mat_q[eidx +: WIDTH];
  assign elem_x = PROD_W'(elem);

  assign acc_nx   = sign ? (acc_q - ACC_W'(prod_q)) : (acc_q + ACC_W'(prod_q));
  assign acc_wide = 64'(acc_nx);
  assign acc_sat  = RES_WIDTH'(sat(acc_wide, RES_WIDTH));

  // Datapath: operand capture, running product and signed accumulation.
  always_ff @(posedge clock) begin
    if (state == ST_IDLE && bus.start) begin
      mat_q  <= bus.matrix;
      prod_q <= PROD_W'(1);
      acc_q  <= '0;
    end else if (state == ST_MUL) begin
      prod_q <= prod_q * elem_x;
    end else if (state == ST_ACC) begin
      acc_q  <= acc_nx;
      prod_q <= PROD_W'(1);
    end
  end

  // Control FSM and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      n_q      <= '0;
      k_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            n_q    <= bus.size;
            k_q    <= '0;
            busy_q <= 1'b1;
            state  <= size_ok ? ST_MUL : ST_FIN;
          end
        end
        ST_MUL: begin
          if (k_q == n_q - SW'(1)) begin
            k_q   <= '0;
            state <= ST_ACC;
          end else begin
            k_q <= k_q + SW'(1);
          end
        end
        ST_ACC: begin
          if (!last) begin
            state <= ST_MUL;
          end else begin
            state    <= ST_FIN;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= acc_sat;
            ovf_q    <= ~fits(acc_wide, RES_WIDTH);
            error_q  <= 1'b0;
          end
        end
        ST_FIN: begin
          // A valid job arrives here with done already raised; an invalid-size job
          // arrives with done low and spends one more cycle to publish the error.
          if (done_q) begin
            done_q <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            error_q  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.overflow = ovf_q;
  assign bus.error    = error_q;

endmodule

// File: tb/tb_mpu_det_seq.sv
// Bench for mpu_det_seq: directed and random jobs against a Bareiss-elimination model.
module tb_mpu_det_seq;

  localparam int WIDTH     = 8;
  localparam int MAX_N     = 5;
  localparam int RES_WIDTH = 16;
  localparam int SW        = $clog2(MAX_N + 1);

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   checks  = 0;
  int   errors  = 0;
  longint ma [MAX_N][MAX_N];

  mpu_det_seq_if #(.WIDTH(WIDTH), .MAX_N(MAX_N), .RES_WIDTH(RES_WIDTH)) bus ();

  mpu_det_seq #(.WIDTH(WIDTH), .MAX_N(MAX_N), .RES_WIDTH(RES_WIDTH)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial forever #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int fact(input int n);
    int f;
    f = 1;
    for (int i = 2; i <= n; i++) f = f * i;
    return f;
  endfunction

  // Exact determinant of the top-left n x n block of ma by fraction-free elimination.
  function automatic longint ref_det(input int n);
    longint m [MAX_N][MAX_N];
    longint prev, t;
    int sgn, p;
    m = ma;
    prev = 1;
    sgn = 1;
    for (int k = 0; k < n - 1; k++) begin
      if (m[k][k] == 0) begin
        p = -1;
        for (int r = k + 1; r < n; r++) if (p < 0 && m[r][k] != 0) p = r;
        if (p < 0) return 0;
        for (int c = 0; c < n; c++) begin
          t = m[k][c]; m[k][c] = m[p][c]; m[p][c] = t;
        end
        sgn = -sgn;
      end
      for (int i = k + 1; i < n; i++)
        for (int j = k + 1; j < n; j++)
          m[i][j] = (m[i][j] * m[k][k] - m[i][k] * m[k][j]) / prev;
      prev = m[k][k];
    end
    return (sgn < 0) ? -m[n-1][n-1] : m[n-1][n-1];
  endfunction

  function automatic logic signed [RES_WIDTH-1:0] sat16(input longint d);
    if (d > 32767) return 16'sh7fff;
    if (d < -32768) return 16'sh8000;
    return RES_WIDTH'(d);
  endfunction

  function automatic logic ovf16(input longint d);
    return (d > 32767) || (d < -32768);
  endfunction

  function automatic logic [WIDTH*MAX_N*MAX_N-1:0] pack_matrix();
    logic [WIDTH*MAX_N*MAX_N-1:0] v;
    v = '0;
    for (int r = 0; r < MAX_N; r++)
      for (int c = 0; c < MAX_N; c++)
        v[WIDTH*(c + MAX_N*r) +: WIDTH] = WIDTH'(ma[r][c]);
    return v;
  endfunction

  task automatic fill_rand();
    for (int r = 0; r < MAX_N; r++)
      for (int c = 0; c < MAX_N; c++)
        ma[r][c] = longint'($urandom_range(200)) - 64'sd100;
  endtask

  task automatic set_diag(input longint v);
    for (int r = 0; r < MAX_N; r++)
      for (int c = 0; c < MAX_N; c++)
        ma[r][c] = (r == c) ? v : 64'sd0;
  endtask

  // Waits for IDLE, issues one job, returns the cycle offset of done (-1 on timeout).
  task automatic run_job(input int n, output int cyc, output logic b1, output logic bd,
                         output logic signed [RES_WIDTH-1:0] r, output logic o, output logic e);
    int guard;
    guard = 0;
    @(negedge clock);
    while ((bus.busy || bus.done) && guard < 1000) begin
      @(negedge clock);
      guard++;
    end
    bus.size   = SW'(n);
    bus.matrix = pack_matrix();
    bus.start  = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    cyc = 1;
    b1  = bus.busy;
    while (!bus.done && cyc < 800) begin
      @(posedge clock); #1;
      cyc++;
    end
    if (!bus.done) cyc = -1;
    bd = bus.busy;
    r  = bus.result;
    o  = bus.overflow;
    e  = bus.error;
  endtask

  task automatic test_reset();
    bus.start  = 1'b0;
    bus.size   = '0;
    bus.matrix = '0;
    reset_n    = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset done: got %b want 0", bus.done); end
    checks++; if (bus.result !== 16'sd0) begin errors++; $display("FAIL reset result: got %0d want 0", bus.result); end
    checks++; if ({bus.overflow, bus.error} !== 2'b00) begin errors++; $display("FAIL reset flags: got %b want 00", {bus.overflow, bus.error}); end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_directed();
    int n, cyc, ecyc;
    logic b1, bd, o, e;
    logic signed [RES_WIDTH-1:0] r;
    longint ed;
    string nm;
    for (int i = 0; i < 7; i++) begin
      fill_rand();
      n = 5; ed = 0; nm = "";
      case (i)
        0: begin nm = "2x2"; n = 2; ma[0][0] = 3; ma[0][1] = 4; ma[1][0] = 2; ma[1][1] = 5; ed = 7; end
        1: begin
             nm = "3x3"; n = 3;
             ma[0][0] = 2; ma[0][1] = 0; ma[0][2] = 1;
             ma[1][0] = 1; ma[1][1] = 3; ma[1][2] = 2;
             ma[2][0] = 1; ma[2][1] = 1; ma[2][2] = 2;
             ed = 6;
           end
        2: begin nm = "1x1"; n = 1; ma[0][0] = -9; ed = -9; end
        3: begin nm = "diag2"; set_diag(2); ed = 32; end
        4: begin
             nm = "diag2_swap"; set_diag(2);
             ma[0][0] = 0; ma[1][1] = 0; ma[0][1] = 2; ma[1][0] = 2;
             ed = -32;
           end
        5: begin nm = "diag127"; set_diag(127); ed = 64'sd33038369407; end
        default: begin nm = "diag-128"; set_diag(-128); ed = -64'sd34359738368; end
      endcase
      ecyc = fact(n) * (n + 1) + 1;
      run_job(n, cyc, b1, bd, r, o, e);
      checks++; if (cyc !== ecyc) begin errors++; $display("FAIL %s done_cycle: got %0d want %0d", nm, cyc, ecyc); end
      checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL %s busy_t1: got %b want 1", nm, b1); end
      checks++; if (bd !== 1'b0) begin errors++; $display("FAIL %s busy_at_done: got %b want 0", nm, bd); end
      checks++; if (r !== sat16(ed)) begin errors++; $display("FAIL %s result: got %0d want %0d", nm, r, sat16(ed)); end
      checks++; if (o !== ovf16(ed)) begin errors++; $display("FAIL %s overflow: got %b want %b", nm, o, ovf16(ed)); end
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL %s error: got %b want 0", nm, e); end
    end
  endtask

  task automatic test_bad_size();
    int cyc;
    int sz [3];
    logic b1, bd, o, e;
    logic signed [RES_WIDTH-1:0] r;
    sz = '{0, 6, 7};
    for (int i = 0; i < 3; i++) begin
      fill_rand();
      run_job(sz[i], cyc, b1, bd, r, o, e);
      checks++; if (cyc !== 2) begin errors++; $display("FAIL bad_size%0d done_cycle: got %0d want 2", sz[i], cyc); end
      checks++; if (b1 !== 1'b1 || bd !== 1'b0) begin errors++; $display("FAIL bad_size%0d busy: got %b%b want 10", sz[i], b1, bd); end
      checks++; if (r !== 16'sd0 || o !== 1'b0) begin errors++; $display("FAIL bad_size%0d result: got %0d/%b want 0/0", sz[i], r, o); end
      checks++; if (e !== 1'b1) begin errors++; $display("FAIL bad_size%0d error: got %b want 1", sz[i], e); end
    end
  endtask

  task automatic test_random();
    int n, cyc, ecyc;
    logic b1, bd, o, e;
    logic signed [RES_WIDTH-1:0] r;
    longint ed;
    for (int i = 0; i < 12; i++) begin
      fill_rand();
      n = (i < 2) ? 5 : int'($urandom_range(4, 1));
      ed = ref_det(n);
      ecyc = fact(n) * (n + 1) + 1;
      run_job(n, cyc, b1, bd, r, o, e);
      checks++; if (cyc !== ecyc) begin errors++; $display("FAIL rand%0d n=%0d done_cycle: got %0d want %0d", i, n, cyc, ecyc); end
      checks++; if (r !== sat16(ed)) begin errors++; $display("FAIL rand%0d n=%0d result: got %0d want %0d (exact %0d)", i, n, r, sat16(ed), ed); end
      checks++; if (o !== ovf16(ed) || e !== 1'b0) begin errors++; $display("FAIL rand%0d n=%0d flags: got %b%b want %b0", i, n, o, e, ovf16(ed)); end
    end
  endtask

  task automatic test_back_to_back();
    int dcyc, ndone;
    logic post_busy;
    logic signed [RES_WIDTH-1:0] r, er;
    fill_rand();
    er = sat16(ref_det(4));
    dcyc = -1; ndone = 0; post_busy = 1'b1; r = '0;
    @(negedge clock);
    while (bus.busy || bus.done) @(negedge clock);
    bus.size   = SW'(4);
    bus.matrix = pack_matrix();
    bus.start  = 1'b1;
    @(posedge clock); #1;
    bus.start  = 1'b0;
    bus.matrix = ~bus.matrix;
    bus.size   = SW'(2);
    for (int t = 1; t < 200; t++) begin
      if (bus.done) begin
        ndone++;
        if (dcyc < 0) begin dcyc = t; r = bus.result; end
      end
      bus.start = (t == 10) || (t == 60) || (t == dcyc);
      @(posedge clock); #1;
      if (t == dcyc) post_busy = bus.busy;
    end
    bus.start = 1'b0;
    checks++; if (dcyc !== 121) begin errors++; $display("FAIL b2b done_cycle: got %0d want 121", dcyc); end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL b2b done_count: got %0d want 1", ndone); end
    checks++; if (r !== er) begin errors++; $display("FAIL b2b result: got %0d want %0d", r, er); end
    checks++; if (post_busy !== 1'b0) begin errors++; $display("FAIL b2b start_in_done_cycle busy: got %b want 0", post_busy); end
    checks++; if (bus.result !== er) begin errors++; $display("FAIL b2b result_held: got %0d want %0d", bus.result, er); end
  endtask

  task automatic test_reset_abort();
    int cyc, ndone;
    logic b1, bd, o, e;
    logic signed [RES_WIDTH-1:0] r;
    set_diag(-128);
    run_job(5, cyc, b1, bd, r, o, e);
    fill_rand();
    set_diag(3);
    @(negedge clock);
    bus.size   = SW'(5);
    bus.matrix = pack_matrix();
    bus.start  = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (49) begin @(posedge clock); #1; end
    reset_n = 1'b0;
    #1;
    checks++; if ({bus.busy, bus.done, bus.overflow, bus.error} !== 4'b0000) begin errors++; $display("FAIL abort flags: got %b want 0000", {bus.busy, bus.done, bus.overflow, bus.error}); end
    checks++; if (bus.result !== 16'sd0) begin errors++; $display("FAIL abort result: got %0d want 0", bus.result); end
    ndone = 0;
    repeat (4) begin @(posedge clock); #1; if (bus.done) ndone++; end
    @(negedge clock);
    reset_n = 1'b1;
    repeat (20) begin @(posedge clock); #1; if (bus.done || bus.busy) ndone++; end
    checks++; if (ndone !== 0) begin errors++; $display("FAIL abort no_done: got %0d events want 0", ndone); end
    fill_rand();
    ma[0][0] = 3; ma[0][1] = 4; ma[1][0] = 2; ma[1][1] = 5;
    run_job(2, cyc, b1, bd, r, o, e);
    checks++; if (cyc !== 7) begin errors++; $display("FAIL post_abort done_cycle: got %0d want 7", cyc); end
    checks++; if (r !== 16'sd7 || o !== 1'b0 || e !== 1'b0) begin errors++; $display("FAIL post_abort result: got %0d/%b/%b want 7/0/0", r, o, e); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_bad_size();
    test_random();
    test_back_to_back();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mpu_det_seq.md
# mpu_det_seq

Sequential, parametrised determinant engine for the matrix processing unit. It accepts one signed square matrix of size 1..MAX_N, selected at run time, through a start/done handshake. It computes the exact determinant with the Leibniz permutation sum, walking the permutations in Heap order with one multiplier and one accumulator. The engine sits beside the other MPU arithmetic ops and is sequenced by the MPU controller.

## Interface
- `WIDTH`, 8, element width in bits (signed two's complement).
- `MAX_N`, 5, largest supported matrix dimension.
- `RES_WIDTH`, 16, width of `result` (signed, saturating).
- `clock` in 1: single rising-edge clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: request. Sampled only in IDLE.
- `size` in $clog2(MAX_N+1): matrix dimension n. Sampled with `start`.
- `matrix` in WIDTH·MAX_N²: element (r,c) at bits `WIDTH*(c+MAX_N*r) +: WIDTH`. Only r,c < n are used. Sampled with `start`.
- `busy` out 1: high from the cycle after acceptance until `done`.
- `done` out 1: one-cycle pulse; `result`, `overflow` and `error` are valid in that cycle and held afterwards.
- `result` out RES_WIDTH: determinant, saturated to the signed RES_WIDTH range.
- `overflow` out 1: exact determinant did not fit in RES_WIDTH.
- `error` out 1: `size` was 0 or greater than MAX_N.

## Operation
- Reset value of all outputs is 0, and the FSM enters IDLE. Reset asserted mid-computation aborts the job with no `done`.
- States are IDLE → MUL → ACC → (MUL | FIN) → IDLE. An invalid size goes IDLE → FIN directly.
- IDLE, on `start`=1:
  - Capture `matrix` and `size` into internal registers; later input changes are ignored.
  - Initialise perm = identity, Heap counters c[1..MAX_N-1] = 0, sign = +1, acc = 0, prod = 1.
  - If `size` is invalid, set the error flag and go to FIN.
- MUL: n cycles. Cycle k (k = 0..n-1) performs prod ← prod · m[k][perm[k]].
  - prod is WIDTH·MAX_N bits signed and never overflows.
- ACC: one cycle.
  - acc ← acc + prod when sign = +1, acc − prod when sign = −1.
  - acc is ACC_W = WIDTH·MAX_N + $clog2(MAX_N!) + 1 bits and never overflows.
  - Same cycle, Heap step: find the smallest i ≥ 1 with i < n and c[i] < i.
    - If found, clear c[1..i-1], increment c[i], swap perm[j] with perm[i] (j = 0 if i is even, else c[i]), flip sign, set prod = 1, go to MUL.
    - If not found, go to FIN.
- FIN: one cycle.
  - Register result = sat(acc), overflow = (acc outside the RES_WIDTH range), error flag.
  - Pulse `done`, drop `busy`, return to IDLE.
  - An error job gives result = 0, overflow = 0, error = 1.
- n = 1 gives a single permutation: result = m[0][0].
- `start` while busy is ignored and not queued.
- `start` in the `done` cycle is ignored. The earliest acceptance is the cycle after `done`.

## Timing
- Let T0 be the cycle where `start` is sampled in IDLE.
- Valid size n: `busy` is high from T0+1 through T0+n!·(n+1), and `done` is high in cycle T0+n!·(n+1)+1.
  - n=1: done at T0+3.
  - n=2: done at T0+7.
  - n=3: done at T0+25.
  - n=4: done at T0+121.
  - n=5: done at T0+721.
- Invalid size: `busy` is high in T0+1 only, and `done` is high in T0+2.
- All outputs are registered. `result`, `overflow` and `error` change only in the `done` cycle or at reset.

## Structure
- Shared package `mpu_pkg` holds:
  - the FSM state enum;
  - the element and flat-matrix index helper `at(r,c)`;
  - the ACC_W width function;
  - the saturation helper, shared with the other MPU ops.
- Sub-module `mpu_perm_gen` is the Heap permutation generator. It owns perm, c[] and sign. Its ports are `init`, `step`, `n`, `perm` (flattened), `sign` and `last`, and the step logic is combinational over one cycle.
- The top level holds the FSM, captured operands, multiplier, accumulator and output registers.

## Test plan
- 2×2 [[3,4],[2,5]], start at T0 → done at T0+7, result=7, overflow=0, error=0.
- 3×3 [[2,0,1],[1,3,2],[1,1,2]] → done at T0+25, result=6. Then 1×1 [[-9]] → done at +3, result=−9.
- 5×5 diag(2,2,2,2,2) → done at T0+721, result=32. The same job with rows 0 and 1 swapped → result=−32.
- 5×5 diag(127,…) → result=32767, overflow=1. 5×5 diag(−128,…) → result=−32768, overflow=1.
- size=0, then size=6 → each gives done at T0+2, error=1, result=0. `start` pulsed while busy during a 4×4 job → no extra `done`, and the first job's result is unchanged.
- `reset_n` dropped at T0+50 of a 5×5 job → all outputs 0 immediately and no `done`. A new 2×2 job started after release completes normally.
